// File: rtl/uart_tx_frame.sv
// Configurable UART transmitter: 5..MAX_DW data bits, optional parity, 1/2 stop bits,
// line break and a 16x oversampling prescaler. One character per valid/ready accept.
module uart_tx_frame #(
  parameter int MAX_DW = 9,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_txen,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [3:0]        cfg_dbits,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_nstop,
  input  logic              cfg_break,
  input  logic              tx_valid,
  input  logic [MAX_DW-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              uart_txd
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t              state_reg;
  logic [MAX_DW-1:0]   data_reg;
  logic [3:0]          dbits_reg;
  logic                par_en_reg;
  logic                par_bit_reg;
  logic                nstop_reg;
  logic                brk_reg;
  logic [DIV_W-1:0]    presc_reg;
  logic [3:0]          tick_cnt_reg;
  logic [3:0]          bit_cnt_reg;
  logic                stop_cnt_reg;
  logic                txd_reg;
  logic                busy_reg;

  logic [3:0]          dbits_clamped;
  logic [MAX_DW-1:0]   data_mask;
  logic                par_next;
  logic                tick;
  logic                bit_end;
  logic                accept;
  logic                last_data;
  logic                last_stop;

  always_comb begin
    dbits_clamped = cfg_dbits;
    if (cfg_dbits < 4'd5)
      dbits_clamped = 4'd5;
    else if (cfg_dbits > 4'(MAX_DW))
      dbits_clamped = 4'(MAX_DW);
  end

  // Parity covers only the data bits that will actually be sent.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_DW; gi = gi + 1) begin : g_mask
      assign data_mask[gi] = (4'(gi) < dbits_clamped);
    end
  endgenerate

  assign par_next  = (^(tx_data & data_mask)) ^ cfg_par_odd;

  // >= keeps the prescaler from running away if cfg_div shrinks mid-count.
  assign tick      = (presc_reg >= cfg_div);
  assign bit_end   = tick && (tick_cnt_reg == 4'd15);
  assign last_data = (bit_cnt_reg == (dbits_reg - 4'd1));
  assign last_stop = (stop_cnt_reg == nstop_reg);

  assign tx_ready  = (state_reg == ST_IDLE) & cfg_txen & ~cfg_break & ~rst;
  assign accept    = tx_valid & tx_ready;
  assign tx_done   = (state_reg == ST_STOP) & bit_end & last_stop & ~brk_reg & ~rst;
  assign tx_busy   = busy_reg;
  assign uart_txd  = txd_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      data_reg     <= '0;
      dbits_reg    <= 4'd0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      nstop_reg    <= 1'b0;
      brk_reg      <= 1'b0;
      presc_reg    <= '0;
      tick_cnt_reg <= 4'd0;
      bit_cnt_reg  <= 4'd0;
      stop_cnt_reg <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      if (state_reg != ST_IDLE) begin
        if (tick) begin
          presc_reg    <= '0;
          tick_cnt_reg <= tick_cnt_reg + 4'd1;
        end else begin
          presc_reg    <= presc_reg + DIV_W'(1);
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (cfg_break) begin
            state_reg    <= ST_BREAK;
            txd_reg      <= 1'b0;
            busy_reg     <= 1'b1;
            brk_reg      <= 1'b1;
            presc_reg    <= '0;
            tick_cnt_reg <= 4'd0;
          end else if (accept) begin
            state_reg    <= ST_START;
            data_reg     <= tx_data & data_mask;
            dbits_reg    <= dbits_clamped;
            par_en_reg   <= cfg_par_en;
            par_bit_reg  <= par_next;
            nstop_reg    <= cfg_nstop;
            brk_reg      <= 1'b0;
            presc_reg    <= '0;
            tick_cnt_reg <= 4'd0;
            bit_cnt_reg  <= 4'd0;
            stop_cnt_reg <= 1'b0;
            txd_reg      <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end

        ST_START: begin
          if (bit_end) begin
            state_reg   <= ST_DATA;
            txd_reg     <= data_reg[0];
            bit_cnt_reg <= 4'd0;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (last_data) begin
              if (par_en_reg) begin
                state_reg <= ST_PARITY;
                txd_reg   <= par_bit_reg;
              end else begin
                state_reg    <= ST_STOP;
                txd_reg      <= 1'b1;
                stop_cnt_reg <= 1'b0;
              end
            end else begin
              data_reg    <= data_reg >> 1;
              txd_reg     <= data_reg[1];
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            state_reg    <= ST_STOP;
            txd_reg      <= 1'b1;
            stop_cnt_reg <= 1'b0;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              brk_reg   <= 1'b0;
            end else begin
              stop_cnt_reg <= 1'b1;
            end
          end
        end

        ST_BREAK: begin
          // Release only on a bit boundary, then one mark bit before idle.
          if (bit_end && !cfg_break) begin
            state_reg    <= ST_STOP;
            txd_reg      <= 1'b1;
            nstop_reg    <= 1'b0;
            stop_cnt_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          txd_reg   <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frame formats, clamping, back-to-back,
// enable gating, line break and mid-frame reset.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_txen;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_dbits;
  logic        cfg_par_en;
  logic        cfg_par_odd;
  logic        cfg_nstop;
  logic        cfg_break;
  logic        tx_valid;
  logic [8:0]  tx_data;
  logic        tx_ready;
  logic        tx_busy;
  logic        tx_done;
  logic        uart_txd;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.MAX_DW(9), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_txen   (cfg_txen),
    .cfg_div    (cfg_div),
    .cfg_dbits  (cfg_dbits),
    .cfg_par_en (cfg_par_en),
    .cfg_par_odd(cfg_par_odd),
    .cfg_nstop  (cfg_nstop),
    .cfg_break  (cfg_break),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .uart_txd   (uart_txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offers one character and checks every cycle of the resulting frame against
  // the expected wire pattern (one char per bit, start bit first).
  task automatic send_frame(input string name, input logic [8:0] data, input logic [3:0] dbits,
                            input logic pen, input logic podd, input logic nstop,
                            input logic [15:0] div, input string exp, input bit hold,
                            input logic [8:0] next_data, output int waited);
    int t;
    int f;
    int b;
    int done_cnt;
    int done_at;
    int busy_bad;
    int bad [16];
    logic exp_bit;
    cfg_div     = div;
    cfg_dbits   = dbits;
    cfg_par_en  = pen;
    cfg_par_odd = podd;
    cfg_nstop   = nstop;
    tx_data     = data;
    tx_valid    = 1'b1;
    #1;
    waited = 0;
    while (tx_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      check({name, " accept timeout"}, 32'd0, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    check({name, " idle txd"}, {31'd0, uart_txd}, 32'd1);
    @(posedge clk);
    #1;
    if (hold) tx_data = next_data;
    else      tx_valid = 1'b0;
    t = 16 * (int'(div) + 1);
    f = exp.len();
    for (int i = 0; i < 16; i++) bad[i] = 0;
    done_cnt = 0;
    done_at  = 0;
    busy_bad = 0;
    for (int c = 1; c <= f * t; c++) begin
      @(negedge clk);
      b = (c - 1) / t;
      exp_bit = (exp[b] == "1");
      if (uart_txd !== exp_bit) bad[b]++;
      if (tx_busy !== 1'b1) busy_bad++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
    end
    for (int i = 0; i < f; i++)
      check($sformatf("%s bit%0d bad cycles", name, i), bad[i], 32'd0);
    check({name, " busy low cycles"}, busy_bad, 32'd0);
    check({name, " done count"}, done_cnt, 32'd1);
    check({name, " done cycle"}, done_at, f * t);
    $display("frame %s data=0x%03h bits=%s done_at=N+%0d waited=%0d", name, data, exp, done_at, waited);
  endtask

  initial begin
    int w;
    int cnt_a;
    int cnt_b;
    int cnt_c;
    int first_high;
    int ready_first;

    rst = 1'b1; cfg_txen = 1'b1; cfg_div = 16'd0; cfg_dbits = 4'd8;
    cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_nstop = 1'b0; cfg_break = 1'b0;
    tx_valid = 1'b0; tx_data = 9'd0;

    repeat (3) @(negedge clk);
    check("reset txd",   {31'd0, uart_txd}, 32'd1);
    check("reset ready", {31'd0, tx_ready}, 32'd0);
    check("reset busy",  {31'd0, tx_busy},  32'd0);
    check("reset done",  {31'd0, tx_done},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post reset ready", {31'd0, tx_ready}, 32'd1);
    $display("reset released");

    // 8N1, div 0
    send_frame("8N1_55", 9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0, "0101010101", 1'b0, 9'd0, w);
    @(negedge clk);
    check("8N1 ready back", {31'd0, tx_ready}, 32'd1);
    check("8N1 busy off",   {31'd0, tx_busy},  32'd0);

    // 7E2, div 1
    send_frame("7E2_41", 9'h041, 4'd7, 1'b1, 1'b0, 1'b1, 16'd1, "01000001011", 1'b0, 9'd0, w);
    @(negedge clk);
    check("7E2 ready back", {31'd0, tx_ready}, 32'd1);

    // 9O1 all ones
    send_frame("9O1_1FF", 9'h1FF, 4'd9, 1'b1, 1'b1, 1'b0, 16'd0, "011111111101", 1'b0, 9'd0, w);
    @(negedge clk);

    // 5E1, upper bits ignored
    send_frame("5E1_1E3", 9'h1E3, 4'd5, 1'b1, 1'b0, 1'b0, 16'd0, "01100001", 1'b0, 9'd0, w);
    @(negedge clk);

    // dbits 3 clamps to 5
    send_frame("clamp_0A", 9'h00A, 4'd3, 1'b0, 1'b0, 1'b0, 16'd0, "0010101", 1'b0, 9'd0, w);
    @(negedge clk);

    // Back-to-back with tx_valid held
    send_frame("b2b_A5", 9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0, "0101001011", 1'b1, 9'h03C, w);
    send_frame("b2b_3C", 9'h03C, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0, "0001111001", 1'b0, 9'd0, w);
    check("b2b accept gap", w, 32'd1);
    @(negedge clk);

    // Enable gating
    cfg_txen = 1'b0; tx_valid = 1'b1; tx_data = 9'h0FF;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx_ready !== 1'b0) cnt_a++;
      if (uart_txd !== 1'b1) cnt_b++;
      if (tx_busy !== 1'b0)  cnt_c++;
    end
    tx_valid = 1'b0; cfg_txen = 1'b1;
    check("txen0 ready cycles", cnt_a, 32'd0);
    check("txen0 txd low",      cnt_b, 32'd0);
    check("txen0 busy cycles",  cnt_c, 32'd0);
    $display("txen gating window done");

    // Break for 100 cycles
    @(negedge clk);
    cfg_div = 16'd0; cfg_break = 1'b1;
    #1;
    check("break ready masked", {31'd0, tx_ready}, 32'd0);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; first_high = 0; ready_first = 0;
    for (int c = 1; c <= 129; c++) begin
      @(negedge clk);
      if (c <= 128) begin
        if (uart_txd === 1'b0) cnt_a++;
        if (uart_txd === 1'b1) begin
          cnt_b++;
          if (first_high == 0) first_high = c;
        end
      end
      if (tx_done === 1'b1) cnt_c++;
      if (tx_ready === 1'b1 && ready_first == 0) ready_first = c;
      if (c == 100) cfg_break = 1'b0;
    end
    check("break low cycles",  cnt_a, 32'd112);
    check("break first mark",  first_high, 32'd113);
    check("break mark cycles", cnt_b, 32'd16);
    check("break ready cycle", ready_first, 32'd129);
    check("break no done",     cnt_c, 32'd0);
    $display("break low=%0d mark=%0d ready_at=%0d", cnt_a, cnt_b, ready_first);

    // Reset mid-DATA
    cfg_dbits = 4'd8; cfg_par_en = 1'b0; cfg_nstop = 1'b0;
    tx_data = 9'h000; tx_valid = 1'b1;
    #1;
    check("rst test ready", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("rst pre txd", {31'd0, uart_txd}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid txd",   {31'd0, uart_txd}, 32'd1);
    check("rst mid busy",  {31'd0, tx_busy},  32'd0);
    check("rst mid done",  {31'd0, tx_done},  32'd0);
    check("rst mid ready", {31'd0, tx_ready}, 32'd0);
    rst = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_done !== 1'b0)  cnt_a++;
      if (uart_txd !== 1'b1) cnt_b++;
    end
    check("rst after done", cnt_a, 32'd0);
    check("rst after txd",  cnt_b, 32'd0);
    check("rst after ready", {31'd0, tx_ready}, 32'd1);
    $display("mid-frame reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, the next generation of the fixed 8N1 transmit path. It accepts one character per valid/ready handshake and serialises it LSB-first on `uart_txd`. Frame format is runtime-configurable: 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits. It also supports line-break generation and a built-in 16x-oversampling baud prescaler. It sits between the TX FIFO/register interface and the pad, and has no other submodules.

## Interface
- `MAX_DW`, default 9: maximum data-bit count; `tx_data` width. Legal values 5–9.
- `DIV_W`, default 16: width of the baud divider.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_txen` in 1: transmitter enable. Gates new accepts only.
- `cfg_div` in DIV_W: prescaler. One oversample tick every `cfg_div+1` clocks; bit time is `16*(cfg_div+1)` clocks.
- `cfg_dbits` in 4: data bits per frame. Values 5–9 are legal; <5 clamps to 5, >MAX_DW clamps to MAX_DW.
- `cfg_par_en` in 1: parity bit present.
- `cfg_par_odd` in 1: 1 selects odd parity, 0 selects even.
- `cfg_nstop` in 1: 0 selects 1 stop bit, 1 selects 2.
- `cfg_break` in 1: request a line break.
- `tx_valid` in 1, `tx_data` in MAX_DW: character input. Bits at or above `cfg_dbits` are ignored.
- `tx_ready` out 1: accept strobe for `tx_valid`.
- `tx_busy` out 1: high in any state other than IDLE.
- `tx_done` out 1: one-cycle pulse at the end of each character frame.
- `uart_txd` out 1: serial output, idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- `tx_ready` is combinational: `(state==IDLE) & cfg_txen & ~cfg_break`. An accept is `tx_valid & tx_ready`.
- On accept, latch `tx_data`, the clamped `cfg_dbits`, `cfg_par_en`, `cfg_par_odd` and `cfg_nstop`. Clear the prescaler and the 16-tick counter, then go to START. Config changes mid-frame have no effect on the current frame; `cfg_div` is not latched.
- On accept, compute the parity bit over the latched data bits `[dbits-1:0]` only. Even parity is the XOR of those bits; odd parity is its inverse.
- A bit ends on the 16th oversample tick. Transitions at bit end:
  - START → DATA.
  - DATA shifts the data register right one bit per bit time. After `dbits` bits it goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY → STOP.
  - STOP lasts `nstop+1` bit times, then → IDLE.
- `uart_txd` is registered:
  - START drives 0.
  - DATA drives the data register LSB.
  - PARITY drives the parity bit.
  - STOP and IDLE drive 1.
  - BREAK drives 0.
- Break: `cfg_break` high in IDLE goes to BREAK, and no accept occurs that cycle. BREAK holds `uart_txd` low for as long as `cfg_break` is high and lasts at least one bit time. After deassertion it completes the current bit time, then goes to STOP with 1 stop bit (one mark bit time), then IDLE. `tx_done` does not pulse after a break.
- `cfg_break` asserted mid-frame takes effect only after that frame returns to IDLE.
- `cfg_txen` deasserted mid-frame: the frame completes normally.
- `cfg_div` changed mid-frame: it applies from the next prescaler reload. This is not a supported use.

## Timing
- Reset values: `uart_txd`=1, `tx_ready`=0 during reset, `tx_busy`=0, `tx_done`=0, state IDLE, all counters 0.
- Reset asserted mid-frame: the next cycle shows `uart_txd`=1 and state IDLE. The character is dropped and there is no `tx_done`.
- Accept in cycle N: `uart_txd` goes 0 in cycle N+1 and `tx_busy`=1 from N+1.
- Frame length: F = 1 + dbits + par_en + nstop + 1 bits. The line is driven for cycles N+1 … N+F·16·(cfg_div+1).
- `tx_done` pulses in the last cycle of the final stop bit. IDLE and `tx_ready` return in the following cycle.
- Back-to-back characters (`tx_valid` held): the next accept comes one cycle after `tx_done`. The next start bit starts two cycles after `tx_done`, giving exactly one extra clock of mark between frames.

## Test plan
- **8N1, minimum divider:** cfg_div=0, dbits=8, no parity, nstop=0, send 0x55.
  - txd: 0,1,0,1,0,1,0,1,0,1, each 16 cycles.
  - `tx_done` at N+160; `tx_ready` back at N+161.
- **7E2:** cfg_div=1, dbits=7, even parity, nstop=1, send 0x41.
  - Bits: 0, 1,0,0,0,0,0,1, parity 0, then 1,1, each 32 cycles.
  - `tx_done` at N+352.
- **9O1, all ones:** dbits=9, odd parity, send 0x1FF.
  - Nine 1s, parity bit 0, then one stop bit.
- **Ignored upper bits:** dbits=5, send 0x1E3. Only bits 1,1,0,0,0 appear; even parity bit = 0.
- **Back-to-back and gating:**
  - Hold `tx_valid` with 0xA5 then 0x3C: both frames appear, separated by exactly one extra mark cycle.
  - `tx_valid` with `cfg_txen`=0: no accept, txd stays 1.
- **Break and reset:**
  - cfg_break high for 100 cycles (cfg_div=0): txd low for 112 cycles (completes the current 16-cycle bit time), then 16 cycles high, then `tx_ready`. No `tx_done`.
  - Assert `rst` mid-DATA: txd=1 on the next cycle and no `tx_done`.
